// File: rtl/booth8_mult_ctrl.sv
// booth8_mult_ctrl: issue/controller stage in front of the radix-8 Booth
// sequential multiplier. It takes one signed operand pair, loads it into the
// multiplier by holding the multiplier's reset low, and waits a fixed number
// of multiplier steps. It then captures the product and hands it downstream
// over a valid/ready handshake.
module booth8_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 11,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_x,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_x,
  output logic                 mult_rstn,
  input  logic [2*WIDTH-1:0]   mult_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Counter value seen on the last RUN edge; RUN lasts exactly ITER cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;

  // Acceptance is a pure decode of the state register, so no input can
  // combinationally reach in_ready.
  assign in_ready = (state_r == IDLE);

  // Job sequencer. Every output it drives is a flop. This matters most for
  // mult_rstn, which feeds the multiplier's asynchronous reset and must not
  // glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      mult_a      <= '0;
      mult_x      <= '0;
      mult_rstn   <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // Keep the multiplier cleared. A new operand pair is latched here
          // and stays stable through LOAD, while mult_rstn is still low.
          mult_rstn <= 1'b0;
          if (in_valid) begin
            mult_a  <= in_a;
            mult_x  <= in_x;
            busy    <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          // The multiplier has sampled the operands while in reset.
          // Releasing reset starts the stepping.
          mult_rstn <= 1'b1;
          cnt_r     <= '0;
          state_r   <= RUN;
        end
        RUN: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= CAPT;
          end
        end
        CAPT: begin
          // The pre-edge product is final. The step the multiplier takes on
          // this same edge is discarded by clearing it again.
          out_product <= mult_product;
          out_valid   <= 1'b1;
          mult_rstn   <= 1'b0;
          state_r     <= DONE;
        end
        DONE: begin
          // Hold the result until downstream takes it. The product register
          // keeps its value after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mult_rstn <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth8_mult_ctrl.sv
// Testbench for booth8_mult_ctrl. A behavioural multiplier sits behind the
// controller. Its product reads as corrupted until the required number of
// steps have passed since load release. Expected products are pushed into a
// scoreboard when an operand pair is accepted. A separate monitor pops and
// compares each product on the output handshake.
module tb_booth8_mult_ctrl;

  localparam int WIDTH = 32;
  localparam int ITER  = 11;
  localparam int CNT_W = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a = '0;
  logic [WIDTH-1:0]     in_x = '0;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_x;
  logic                 mult_rstn;
  logic [2*WIDTH-1:0]   mult_product;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;

  int n_chk = 0;
  int n_fail = 0;

  booth8_mult_ctrl #(.WIDTH(WIDTH), .ITER(ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_x(in_x),
    .mult_a(mult_a), .mult_x(mult_x), .mult_rstn(mult_rstn),
    .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: it captures operands while its reset is low and
  // counts its steps after release. It shows the true product only after
  // ITER steps.
  logic [WIDTH-1:0] m_a, m_x;
  int               m_steps;
  longint           m_full;

  always @(posedge clk or negedge mult_rstn) begin
    if (!mult_rstn) begin
      m_a     <= mult_a;
      m_x     <= mult_x;
      m_steps <= 0;
    end else begin
      m_steps <= m_steps + 1;
    end
  end

  assign m_full       = longint'($signed(m_a)) * longint'($signed(m_x));
  assign mult_product = (m_steps >= ITER) ? m_full : (m_full ^ 64'hA5A5_5A5A_0F0F_F0F0);

  // Scoreboard state
  longint      exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          cyc = 0;
  logic        exp_ready = 1'b1;
  logic        ov_prev = 1'b0;
  logic        or_prev = 1'b0;
  logic [63:0] prod_prev = '0;
  logic [63:0] last_prod = '0;
  logic        rand_bp = 1'b0;

  // Monitor: samples pre-edge values at every rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rstn) begin
      exp_q.delete();
      lat_q.delete();
      exp_ready = 1'b1;
      ov_prev   = 1'b0;
      or_prev   = 1'b0;
    end else begin
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      if (exp_q.size() == 0) chk("no_spurious_valid", out_valid, 1'b0);
      if (out_valid && !ov_prev && lat_q.size() != 0) begin
        chk("latency", cyc - 1, lat_q.pop_front() + ITER + 2);
      end
      if (out_valid && ov_prev && !or_prev) chk("hold_product", out_product, prod_prev);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("product", out_product, exp_q.pop_front());
        last_prod = out_product;
        exp_ready = 1'b1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(longint'($signed(in_a)) * longint'($signed(in_x)));
        lat_q.push_back(cyc);
        acc_q.push_back(cyc);
        exp_ready = 1'b0;
      end
      ov_prev   = out_valid;
      or_prev   = out_ready;
      prod_prev = out_product;
    end
  end

  // Random downstream backpressure during the randomized phase
  always @(negedge clk) begin
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Present an operand pair and wait for its acceptance. Returns on the
  // falling edge after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] x, input bit hold);
    int b;
    in_a = a;
    in_x = x;
    in_valid = 1'b1;
    b = 0;
    while (!in_ready && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
    end else begin
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || out_valid) && b < 400) begin
      @(negedge clk);
      b++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_mult_a", mult_a, 32'd0);
    chk("rst_mult_x", mult_x, 32'd0);
    chk("rst_mult_rstn", mult_rstn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic job and signed corner cases
    issue(32'd3, 32'd5, 1'b0);
    drain();
    chk("tp_3x5", last_prod, 64'd15);
    issue(-32'sd7, 32'd6, 1'b0);
    drain();
    chk("tp_m7x6", last_prod, 64'hFFFF_FFFF_FFFF_FFD6);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    drain();
    chk("tp_maxpos", last_prod, 64'h3FFF_FFFF_0000_0001);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();
    chk("tp_minneg_sq", last_prod, 64'h4000_0000_0000_0000);
    issue(32'h8000_0000, 32'd1, 1'b0);
    drain();
    chk("tp_minneg_x1", last_prod, 64'hFFFF_FFFF_8000_0000);

    // Backpressure with a pending operand pair
    out_ready = 1'b0;
    issue(32'd11, -32'sd13, 1'b0);
    for (int b = 0; b < 400 && !out_valid; b++) @(negedge clk);
    chk("bp_valid_rose", out_valid, 1'b1);
    in_a = 32'd5;
    in_x = 32'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_queue", exp_q.size(), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", out_valid, 1'b0);
    chk("bp_released_ready", in_ready, 1'b1);
    chk("bp_product", last_prod, 64'hFFFF_FFFF_FFFF_FF71);
    issue(32'd5, 32'd9, 1'b0);
    drain();
    chk("bp_pending", last_prod, 64'd45);

    // Back-to-back with in_valid held high
    acc_q.delete();
    issue(32'd100, 32'd200, 1'b1);
    issue(-32'sd1, -32'sd1, 1'b1);
    issue(32'h1234_5678, -32'sd3, 1'b1);
    issue(32'd0, 32'hDEAD_BEEF, 1'b0);
    drain();
    chk("b2b_count", acc_q.size(), 4);
    for (int i = 0; i + 1 < acc_q.size(); i++) begin
      chk("b2b_spacing", acc_q[i+1] - acc_q[i], ITER + 4);
    end

    // Randomized operands, gaps and backpressure
    rand_bp = 1'b1;
    for (int j = 0; j < 12; j++) begin
      logic [WIDTH-1:0] ra, rx;
      ra = $urandom;
      rx = $urandom;
      if (j == 3) ra = 32'h8000_0000;
      if (j == 7) rx = 32'hFFFF_FFFF;
      issue(ra, rx, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rand_bp = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset asserted in RUN with cnt=5
    issue(32'd123, 32'd456, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_mult_rstn_high", mult_rstn, 1'b1);
    rstn = 1'b0;
    #1;
    chk("mid_mult_rstn", mult_rstn, 1'b0);
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_in_ready", in_ready, 1'b1);
    chk("mid_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    issue(32'd2, -32'sd3, 1'b0);
    drain();
    chk("post_rst_job", last_prod, 64'hFFFF_FFFF_FFFF_FFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
